// File: rtl/mac_sum_stage_if.sv
// mac_sum_stage_if: upstream and downstream bundle of the MAC sum stage.
// The master drives operands and ready_i; the slave is the sum stage.
interface mac_sum_stage_if #(
   parameter int PARM_EXP  = 8,
   parameter int PARM_MANT = 23
);
   localparam int P = 2*PARM_MANT+2;
   localparam int W = 3*PARM_MANT+6;
   localparam int E = PARM_EXP+2;

   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] A_Mant_aligned_i;
   logic [P-1:0] Wallace_sum_i;
   logic [P-1:0] Wallace_carry_i;
   logic         Sub_Sign_i;
   logic [E-1:0] Exp_i;
   logic         Sign_i;
   logic         Sticky_i;

   logic         valid_o;
   logic         ready_i;
   logic [W-2:0] Mant_o;
   logic [6:0]   Lzc_o;
   logic [E-1:0] Exp_o;
   logic         Sign_o;
   logic         Sticky_o;
   logic         Sign_change_o;
   logic         Zero_o;

   modport master (
      output valid_i, A_Mant_aligned_i, Wallace_sum_i,
      output Wallace_carry_i, Sub_Sign_i, Exp_i,
      output Sign_i, Sticky_i, ready_i,
      input  ready_o, valid_o, Mant_o, Lzc_o, Exp_o,
      input  Sign_o, Sticky_o, Sign_change_o, Zero_o
   );

   modport slave (
      input  valid_i, A_Mant_aligned_i, Wallace_sum_i,
      input  Wallace_carry_i, Sub_Sign_i, Exp_i,
      input  Sign_i, Sticky_i, ready_i,
      output ready_o, valid_o, Mant_o, Lzc_o, Exp_o,
      output Sign_o, Sticky_o, Sign_change_o, Zero_o
   );
endinterface

// File: rtl/mac_sum_stage.sv
// mac_sum_stage: elastic two-stage CSA/CPA merge of addend and Wallace
// vectors into a sign-magnitude sum with leading-zero count.
module mac_sum_stage #(
   parameter int PARM_EXP  = 8,
   parameter int PARM_MANT = 23
) (
   input  logic           clk_i,
   input  logic           rst_i,
   mac_sum_stage_if.slave bus
);
   localparam int P = 2*PARM_MANT+2;
   localparam int W = 3*PARM_MANT+6;
   localparam int E = PARM_EXP+2;
   localparam int H = W-P;

   logic         s1_valid_q, s1_valid_d;
   logic [P-1:0] csa_s_q, csa_s_d;
   logic [P-1:0] csa_c_q, csa_c_d;
   logic [H-1:0] a_hi_q;
   logic         sub_q;
   logic [E-1:0] exp_q;
   logic         sign_q;
   logic         sticky_q;

   logic         s2_valid_q, s2_valid_d;
   logic [W-2:0] mant_q, mant_d;
   logic [6:0]   lzc_q, lzc_d;
   logic [E-1:0] exp2_q;
   logic         sign2_q, sign2_d;
   logic         sticky2_q;
   logic         sc_q, sc_d;
   logic         zero_q, zero_d;

   logic         s2_load;
   logic         s1_load;
   logic         s1_adv;
   logic [W-1:0] t;
   logic [W-1:0] t_neg;
   logic         found;

   assign s2_load    = ~s2_valid_q | bus.ready_i;
   assign bus.ready_o = ~s1_valid_q | s2_load;
   assign s1_load    = bus.valid_i & bus.ready_o;
   assign s1_adv     = s1_valid_q & s2_load;

   always_comb begin
      csa_s_d = bus.A_Mant_aligned_i[P-1:0]
              ^ bus.Wallace_sum_i
              ^ bus.Wallace_carry_i;
      csa_c_d = (bus.A_Mant_aligned_i[P-1:0] & bus.Wallace_sum_i)
              | (bus.A_Mant_aligned_i[P-1:0] & bus.Wallace_carry_i)
              | (bus.Wallace_sum_i & bus.Wallace_carry_i);
      s1_valid_d = bus.ready_o ? bus.valid_i : s1_valid_q;
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
   end

   always_comb begin
      t = {a_hi_q, {P{1'b0}}}
        + W'(csa_s_q)
        + W'({csa_c_q, 1'b0})
        + W'(sub_q);
      t_neg  = -t;
      zero_d = (t == '0);
      mant_d = t[W-2:0];
      sign2_d = sign_q;
      sc_d    = 1'b0;
      if (t[W-1]) begin
         mant_d  = t_neg[W-2:0];
         sign2_d = ~sign_q;
         sc_d    = 1'b1;
      end
      // An exact cancellation under subtraction is reported as +0.
      if (zero_d) sign2_d = sign_q & ~sub_q;
      lzc_d = 7'(W-1);
      found = 1'b0;
      for (int i = W-2; i >= 0; i--) begin
         if (!found && mant_d[i]) begin
            lzc_d = 7'(W-2-i);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         csa_s_q    <= '0;
         csa_c_q    <= '0;
         a_hi_q     <= '0;
         sub_q      <= 1'b0;
         exp_q      <= '0;
         sign_q     <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_load) begin
            csa_s_q  <= csa_s_d;
            csa_c_q  <= csa_c_d;
            a_hi_q   <= bus.A_Mant_aligned_i[W-1:P];
            sub_q    <= bus.Sub_Sign_i;
            exp_q    <= bus.Exp_i;
            sign_q   <= bus.Sign_i;
            sticky_q <= bus.Sticky_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid_q <= 1'b0;
         mant_q     <= '0;
         lzc_q      <= '0;
         exp2_q     <= '0;
         sign2_q    <= 1'b0;
         sticky2_q  <= 1'b0;
         sc_q       <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s1_adv) begin
            mant_q    <= mant_d;
            lzc_q     <= lzc_d;
            exp2_q    <= exp_q;
            sign2_q   <= sign2_d;
            sticky2_q <= sticky_q;
            sc_q      <= sc_d;
            zero_q    <= zero_d;
         end
      end
   end

   assign bus.valid_o       = s2_valid_q;
   assign bus.Mant_o        = mant_q;
   assign bus.Lzc_o         = lzc_q;
   assign bus.Exp_o         = exp2_q;
   assign bus.Sign_o        = sign2_q;
   assign bus.Sticky_o      = sticky2_q;
   assign bus.Sign_change_o = sc_q;
   assign bus.Zero_o        = zero_q;
endmodule

// File: tb/tb_mac_sum_stage.sv
// tb_mac_sum_stage: directed vector table plus backpressure, streaming
// and mid-flight reset sequences for the MAC sum stage.
`timescale 1ns/1ps
module tb_mac_sum_stage;
   localparam int PE = 8;
   localparam int PM = 23;
   localparam int P  = 2*PM+2;
   localparam int W  = 3*PM+6;
   localparam int E  = PE+2;
   localparam logic [W-1:0] ONES = '1;

   typedef struct {
      logic [W-1:0] a;
      logic [P-1:0] s;
      logic [P-1:0] c;
      logic         sub;
      logic [E-1:0] exp;
      logic         sign;
      logic         sticky;
   } in_t;

   typedef struct {
      logic [W-2:0] mant;
      logic [6:0]   lzc;
      logic [E-1:0] exp;
      logic         sign;
      logic         sticky;
      logic         sc;
      logic         zero;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mac_sum_stage_if #(.PARM_EXP(PE), .PARM_MANT(PM)) bus ();

   mac_sum_stage #(.PARM_EXP(PE), .PARM_MANT(PM)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int   checks = 0;
   int   fails  = 0;
   int   n_in   = 0;
   int   n_out  = 0;
   in_t  src[$];
   out_t expq[$];
   vec_t vecs[9];

   task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic chk_out(string nm, out_t e);
      chk({nm, ".mant"}, W'(bus.Mant_o), W'(e.mant));
      chk({nm, ".lzc"}, W'(bus.Lzc_o), W'(e.lzc));
      chk({nm, ".exp"}, W'(bus.Exp_o), W'(e.exp));
      chk({nm, ".sign"}, W'(bus.Sign_o), W'(e.sign));
      chk({nm, ".sticky"}, W'(bus.Sticky_o), W'(e.sticky));
      chk({nm, ".schg"}, W'(bus.Sign_change_o), W'(e.sc));
      chk({nm, ".zero"}, W'(bus.Zero_o), W'(e.zero));
   endtask

   function automatic out_t model(in_t v);
      logic [W-1:0] t;
      logic [W-1:0] m;
      out_t r;
      t = v.a + W'(v.s) + W'(v.c) + W'(v.sub);
      m = t[W-1] ? (~t + W'(1)) : t;
      r.mant   = m[W-2:0];
      r.zero   = (t == '0);
      r.sc     = t[W-1];
      r.sign   = r.zero ? (v.sign & ~v.sub) : (v.sign ^ t[W-1]);
      r.lzc    = 7'(W-1);
      for (int k = 0; k < W-1; k++)
         if (r.mant[k]) r.lzc = 7'(W-2-k);
      r.exp    = v.exp;
      r.sticky = v.sticky;
      return r;
   endfunction

   function automatic vec_t mkv(
      logic [W-1:0] a, logic [P-1:0] s, logic [P-1:0] c,
      logic sub, logic [E-1:0] exp, logic sign, logic sticky,
      logic [W-2:0] mant, logic [6:0] lzc,
      logic so, logic sc, logic z);
      vec_t v;
      v.i.a = a;
      v.i.s = s;
      v.i.c = c;
      v.i.sub = sub;
      v.i.exp = exp;
      v.i.sign = sign;
      v.i.sticky = sticky;
      v.o.mant = mant;
      v.o.lzc = lzc;
      v.o.exp = exp;
      v.o.sign = so;
      v.o.sticky = sticky;
      v.o.sc = sc;
      v.o.zero = z;
      return v;
   endfunction

   function automatic in_t rnd_in();
      in_t v;
      logic [69:0] m;
      m = 70'({$urandom, $urandom, $urandom});
      v.a = {{5{m[69]}}, m};
      v.s = 48'({$urandom, $urandom});
      v.c = 48'({$urandom, $urandom});
      v.sub = 1'($urandom_range(0, 1));
      v.exp = 10'($urandom);
      v.sign = 1'($urandom_range(0, 1));
      v.sticky = 1'($urandom_range(0, 1));
      return v;
   endfunction

   task automatic drive(in_t v);
      bus.valid_i = 1'b1;
      bus.A_Mant_aligned_i = v.a;
      bus.Wallace_sum_i = v.s;
      bus.Wallace_carry_i = v.c;
      bus.Sub_Sign_i = v.sub;
      bus.Exp_i = v.exp;
      bus.Sign_i = v.sign;
      bus.Sticky_i = v.sticky;
   endtask

   // One handshake cycle: drive, settle, then score both ports.
   task automatic cycle(logic rdy, logic vld);
      @(negedge clk);
      bus.ready_i = rdy;
      if (vld && src.size() > 0) drive(src[0]);
      else bus.valid_i = 1'b0;
      #1;
      if (bus.valid_o && bus.ready_i) begin
         if (expq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL extra_out: got valid_o=1 expected 0");
         end else begin
            chk_out("out", expq.pop_front());
         end
         n_out++;
      end else if (bus.valid_o && expq.size() > 0) begin
         chk_out("stall", expq[0]);
      end
      if (bus.valid_i && bus.ready_o) begin
         expq.push_back(model(src.pop_front()));
         n_in++;
      end
   endtask

   task automatic apply_vec(string nm, vec_t v);
      @(negedge clk);
      bus.ready_i = 1'b1;
      drive(v.i);
      #1;
      chk({nm, ".rdy"}, W'(bus.ready_o), W'(1));
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      chk({nm, ".lat1"}, W'(bus.valid_o), W'(0));
      @(negedge clk);
      #1;
      chk({nm, ".lat2"}, W'(bus.valid_o), W'(1));
      chk_out(nm, v.o);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.A_Mant_aligned_i = '0;
      bus.Wallace_sum_i = '0;
      bus.Wallace_carry_i = '0;
      bus.Sub_Sign_i = 1'b0;
      bus.Exp_i = '0;
      bus.Sign_i = 1'b0;
      bus.Sticky_i = 1'b0;

      vecs[0] = mkv('0, 48'd5, 48'd3, 0, 10'h0A0, 0, 0,
                    74'd8, 7'd70, 0, 0, 0);
      vecs[1] = mkv(ONES - 75'd9, 48'd3, 48'd2, 1, 10'h155, 0, 1,
                    74'd4, 7'd71, 1, 1, 0);
      vecs[2] = mkv(ONES - 75'd5, 48'd3, 48'd2, 1, 10'h3FF, 1, 0,
                    74'd0, 7'd74, 0, 0, 1);
      vecs[3] = mkv('0, '0, '0, 0, 10'h001, 1, 1,
                    74'd0, 7'd74, 1, 0, 1);
      vecs[4] = mkv('0, {P{1'b1}}, 48'd1, 0, 10'h2AA, 1, 0,
                    74'd1 << 48, 7'd25, 1, 0, 0);
      vecs[5] = mkv({1'b0, {74{1'b1}}}, '0, '0, 0, 10'h100, 0, 1,
                    {74{1'b1}}, 7'd0, 0, 0, 0);
      vecs[6] = mkv(ONES << 60, '0, '0, 0, 10'h07F, 0, 0,
                    74'd1 << 60, 7'd13, 1, 1, 0);
      vecs[7] = mkv(75'd1 << 47, 48'd1 << 47, 48'd1 << 47, 0,
                    10'h0F0, 1, 1, 74'd3 << 47, 7'd25, 1, 0, 0);
      vecs[8] = mkv(~75'd100, 48'd50, '0, 1, 10'h011, 1, 0,
                    74'd50, 7'd68, 0, 1, 0);

      #1 rst = 1'b1;
      #2;
      chk("rst.valid", W'(bus.valid_o), W'(0));
      chk("rst.mant", W'(bus.Mant_o), W'(0));
      chk("rst.lzc", W'(bus.Lzc_o), W'(0));
      chk("rst.exp", W'(bus.Exp_o), W'(0));
      chk("rst.flags", W'({bus.Sign_o, bus.Sticky_o,
          bus.Sign_change_o, bus.Zero_o}), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.ready", W'(bus.ready_o), W'(1));

      for (int i = 0; i < 9; i++)
         apply_vec($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: five inputs against a stalled consumer.
      @(negedge clk);
      n_in = 0;
      n_out = 0;
      for (int i = 0; i < 5; i++) src.push_back(rnd_in());
      repeat (6) cycle(1'b0, 1'b1);
      chk("bp.accepted", W'(n_in), W'(2));
      chk("bp.ready_low", W'(bus.ready_o), W'(0));
      chk("bp.valid", W'(bus.valid_o), W'(1));
      begin
         int cnt;
         cnt = 0;
         while (n_out < 5 && cnt < 20) begin
            cycle(1'b1, 1'b1);
            cnt++;
         end
         chk("bp.cycles", W'(cnt), W'(5));
      end
      chk("bp.out", W'(n_out), W'(5));
      chk("bp.left", W'(expq.size() + src.size()), W'(0));

      // Streaming with random valid and ready.
      n_in = 0;
      n_out = 0;
      for (int i = 0; i < 100; i++) src.push_back(rnd_in());
      begin
         int cnt;
         cnt = 0;
         while (n_out < 100 && cnt < 3000) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 80));
            cnt++;
         end
      end
      chk("st.in", W'(n_in), W'(100));
      chk("st.out", W'(n_out), W'(100));

      // Reset while S2 holds a result and S1 is full.
      n_in = 0;
      n_out = 0;
      expq.delete();
      src.delete();
      for (int i = 0; i < 2; i++) begin
         in_t v;
         v = rnd_in();
         v.exp = 10'h3C3;
         v.sticky = 1'b1;
         src.push_back(v);
      end
      repeat (3) cycle(1'b0, 1'b1);
      chk("mr.pre_valid", W'(bus.valid_o), W'(1));
      chk("mr.pre_ready", W'(bus.ready_o), W'(0));
      #1 rst = 1'b1;
      #1;
      chk("mr.valid", W'(bus.valid_o), W'(0));
      chk("mr.mant", W'(bus.Mant_o), W'(0));
      chk("mr.lzc", W'(bus.Lzc_o), W'(0));
      chk("mr.exp", W'(bus.Exp_o), W'(0));
      chk("mr.flags", W'({bus.Sign_o, bus.Sticky_o,
          bus.Sign_change_o, bus.Zero_o}), W'(0));
      bus.valid_i = 1'b0;
      expq.delete();
      src.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mr.ready", W'(bus.ready_o), W'(1));
      apply_vec("mr.vec", vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
